// File: rtl/i2c_target_if.sv
`default_nettype none
//==============================================================================
// Module      : i2c_target_if
// Description : Pad-side and user-side signal bundle of the I2C target.
// Revision    : 1.0 - initial release
//==============================================================================
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addr_hit;
  logic       busy;
`ifdef I2C_TARGET_GENCALL_EN
  logic       gencall;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addr_hit, busy, gencall
  );
  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addr_hit, busy, gencall
  );
`else
  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addr_hit, busy
  );
  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addr_hit, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
//==============================================================================
// Module      : i2c_target
// Description : Oversampled I2C target: 7-bit address match, write/read with
//               ACK/NACK, open-drain SDA. General call via I2C_TARGET_GENCALL_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  i2c_target_if.slave bus
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_addr      = 3'd1;
  localparam logic [2:0] c_st_addr_ack  = 3'd2;
  localparam logic [2:0] c_st_rx        = 3'd3;
  localparam logic [2:0] c_st_rx_ack    = 3'd4;
  localparam logic [2:0] c_st_tx        = 3'd5;
  localparam logic [2:0] c_st_tx_ack    = 3'd6;
  localparam logic [2:0] c_st_wait_stop = 3'd7;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl_s, w_sda_s;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]             w_byte_in;
  logic                   w_gc_in, w_addr_ok;

  logic [2:0] r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_done, w_done_nxt;
  logic       r_oe, w_oe_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_hit, w_hit_nxt;

  // Synchronisers reset to the idle-bus level so release never fakes a START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  assign w_start    = w_scl_s & r_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & ~r_sda_d & w_sda_s;
  assign w_byte_in  = {r_shift[6:0], w_sda_s};
  assign w_addr_ok  = (w_byte_in[7:1] == ADDR) | w_gc_in;

`ifdef I2C_TARGET_GENCALL_EN
  logic r_gc;

  // General call only as a write: 0x01 is left to the normal mismatch path.
  assign w_gc_in = (w_byte_in == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gc <= 1'b0;
    end else if (w_start || w_stop) begin
      r_gc <= 1'b0;
    end else if (r_state == c_st_addr && r_done && w_scl_fall) begin
      r_gc <= (r_shift == 8'h00);
    end
  end

  assign bus.gencall = r_gc;
`else
  assign w_gc_in = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_cnt      <= 3'd7;
      r_shift    <= 8'h00;
      r_done     <= 1'b0;
      r_oe       <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_hit      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_done     <= w_done_nxt;
      r_oe       <= w_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_hit      <= w_hit_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_done_nxt     = r_done;
    w_oe_nxt       = r_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_hit_nxt      = r_hit;
    if (w_stop) begin
      w_state_nxt = c_st_idle;
      w_oe_nxt    = 1'b0;
      w_hit_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = c_st_addr;
      w_cnt_nxt   = 3'd7;
      w_shift_nxt = 8'h00;
      w_oe_nxt    = 1'b0;
      w_hit_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        c_st_addr: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte_in;
            if (r_cnt == 3'd0) begin
              if (w_addr_ok) w_done_nxt  = 1'b1;
              else           w_state_nxt = c_st_wait_stop;
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end else if (w_scl_fall && r_done) begin
            w_done_nxt  = 1'b0;
            w_oe_nxt    = 1'b1;
            w_hit_nxt   = (r_shift[7:1] == ADDR);
            w_state_nxt = c_st_addr_ack;
          end
        end
        c_st_addr_ack: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 3'd7;
            if (!r_shift[0]) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = c_st_rx;
            end else begin
              w_shift_nxt  = bus.tx_data;
              w_tx_req_nxt = 1'b1;
              w_oe_nxt     = ~bus.tx_data[7];
              w_state_nxt  = c_st_tx;
            end
          end
        end
        c_st_rx: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte_in;
            if (r_cnt == 3'd0) begin
              w_rx_data_nxt  = w_byte_in;
              w_rx_valid_nxt = 1'b1;
              w_done_nxt     = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt - 3'd1;
            end
          end else if (w_scl_fall && r_done) begin
            w_done_nxt  = 1'b0;
            w_oe_nxt    = 1'b1;
            w_state_nxt = c_st_rx_ack;
          end
        end
        c_st_rx_ack: begin
          if (w_scl_fall) begin
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 3'd7;
            w_state_nxt = c_st_rx;
          end
        end
        c_st_tx: begin
          // r_shift[7] is the bit on the wire; shifting exposes the next one.
          if (w_scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = c_st_tx_ack;
            end else begin
              w_cnt_nxt   = r_cnt - 3'd1;
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
            end
          end
        end
        c_st_tx_ack: begin
          if (w_scl_rise && w_sda_s) begin
            w_state_nxt = c_st_wait_stop;
          end else if (w_scl_fall) begin
            w_shift_nxt  = bus.tx_data;
            w_tx_req_nxt = 1'b1;
            w_oe_nxt     = ~bus.tx_data[7];
            w_cnt_nxt    = 3'd7;
            w_state_nxt  = c_st_tx;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.sda_oe   = r_oe;
    bus.rx_data  = r_rx_data;
    bus.rx_valid = r_rx_valid;
    bus.tx_req   = r_tx_req;
    bus.addr_hit = r_hit;
    bus.busy     = (r_state != c_st_idle);
  end

endmodule
`default_nettype wire
